vga_pattern_gen: RTL and testbench

Pixel-colour stage directly downstream of the VGA sync generator: consumes its sync, active-area and pixel-coordinate outputs and drives the 3-bit-per-channel RGB pins together with delay-matched HSync/VSync. A pattern code, typically written from the UART receive byte, selects one of six test patterns. The new selection takes effect only at a frame boundary, so no frame is ever torn. A frame counter animates one moving pattern.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_pattern_gen_if.sv | 12 +
 rtl/vga_pattern_colour.sv | 49 ++++
 rtl/vga_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: pattern codes,
// active-area sizes and the RGB colour type.
package vga_pkg;

    localparam int COLOUR_W    = 3;
    localparam int H_ACTIVE_PX = 640;
    localparam int V_ACTIVE_PX = 480;

    typedef logic [2:0]          pattern_t;
    typedef logic [COLOUR_W-1:0] colour_t;

    typedef struct packed {
        colour_t red;
        colour_t green;
        colour_t blue;
    } rgb_t;

    localparam pattern_t PAT_OFF      = 3'd0;
    localparam pattern_t PAT_WHITE    = 3'd1;
    localparam pattern_t PAT_BARS     = 3'd2;
    localparam pattern_t PAT_CHECKER  = 3'd3;
    localparam pattern_t PAT_GRADIENT = 3'd4;
    localparam pattern_t PAT_MOVBAR   = 3'd5;

    localparam colour_t COL_MAX = colour_t'(3'd7);

    // True when the code names one of the six defined patterns.
    function automatic logic isValidPattern(input pattern_t code);
        return (code <= PAT_MOVBAR);
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pattern-request channel: a strobed pattern code in, an error pulse out.
interface vga_pattern_gen_if;
    import vga_pkg::*;

    logic     i_patternValid;
    pattern_t i_pattern;
    logic     o_errorFlag;

    modport master (output i_patternValid, output i_pattern, input o_errorFlag);
    modport slave  (input i_patternValid, input i_pattern, output o_errorFlag);

endinterface

// File: rtl/vga_pattern_colour.sv
// Combinational colour lookup: maps pattern, pixel coordinate and moving-bar
// position to a 3-bit-per-channel RGB value.
module vga_pattern_colour
    import vga_pkg::*;
(
    input  pattern_t   i_pattern,
    input  logic [9:0] i_px,
    input  logic [9:0] i_py,
    input  logic [9:0] i_pos,
    output rgb_t       o_rgb
);

    logic [10:0] w_barEnd;
    logic        w_barLit;
    logic        w_checkLit;
    logic [2:0]  w_barIdx;
    logic        w_unusedPy;

    // The bar end is computed one bit wider so pos + 15 never wraps; columns
    // past 639 are blanked upstream, which clips the bar at the right edge.
    assign w_barEnd   = {1'b0, i_pos} + 11'd15;
    assign w_barLit   = (i_px >= i_pos) && ({1'b0, i_px} <= w_barEnd);
    assign w_checkLit = i_px[5] ^ i_py[5];
    assign w_barIdx   = i_px[8:6];
    assign w_unusedPy = ^{i_py[9], i_py[4:0]};

    // Select the colour for the current pixel from the active pattern.
    always_comb begin
        o_rgb = '0;
        case (i_pattern)
            PAT_OFF:      o_rgb = '0;
            PAT_WHITE:    o_rgb = '{COL_MAX, COL_MAX, COL_MAX};
            PAT_BARS: begin
                o_rgb.red   = w_barIdx[2] ? COL_MAX : '0;
                o_rgb.green = w_barIdx[1] ? COL_MAX : '0;
                o_rgb.blue  = w_barIdx[0] ? COL_MAX : '0;
            end
            PAT_CHECKER:  o_rgb = w_checkLit ? '{COL_MAX, COL_MAX, COL_MAX} : '0;
            PAT_GRADIENT: begin
                o_rgb.red   = i_px[8:6];
                o_rgb.green = i_py[8:6];
                o_rgb.blue  = '0;
            end
            PAT_MOVBAR:   o_rgb = w_barLit ? '{COL_MAX, COL_MAX, COL_MAX} : '0;
            default:      o_rgb = '0;
        endcase
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA pattern generator: latches pattern requests, swaps pattern and steps
// the moving bar at each frame edge, and drives RGB plus syncs through a
// two-stage pipeline so colour and sync stay aligned.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int H_ACTIVE        = H_ACTIVE_PX,
    parameter int BAR_STEP        = 4
)
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_hs,
    input  logic                i_vs,
    input  logic                i_activeArea,
    input  logic [9:0]          i_px,
    input  logic [9:0]          i_py,
    vga_pattern_gen_if.slave    patIf,
    output logic                o_hs,
    output logic                o_vs,
    output colour_t             o_red,
    output colour_t             o_green,
    output colour_t             o_blue
);

    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic        w_frameEdge;
    logic        w_strobeOk;
    logic        w_strobeBad;
    logic [10:0] w_posSum;
    logic [9:0]  w_posNext;
    rgb_t        w_rgb;

    pattern_t    r_pendCode;
    logic        r_pendFlag;
    pattern_t    r_curPattern;
    logic [9:0]  r_pos;
    logic        r_errorFlag;

    logic [9:0]  r_px1;
    logic [9:0]  r_py1;
    logic        r_act1;
    logic        r_hs1;
    logic        r_vs1;
    pattern_t    r_pat1;
    logic [9:0]  r_pos1;

    rgb_t        r_rgb2;
    logic        r_hs2;
    logic        r_vs2;

    // r_vs1 doubles as the registered vsync used for edge detection.
    assign w_frameEdge = (i_vs != SYNC_IDLE) && (r_vs1 == SYNC_IDLE);
    assign w_strobeOk  = patIf.i_patternValid && isValidPattern(patIf.i_pattern);
    assign w_strobeBad = patIf.i_patternValid && !isValidPattern(patIf.i_pattern);
    assign w_posSum    = {1'b0, r_pos} + 11'(BAR_STEP);
    assign w_posNext   = (w_posSum >= 11'(H_ACTIVE)) ? '0 : w_posSum[9:0];

    // Hold the latest valid request; a strobe on the edge cycle survives the clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pendCode <= PAT_OFF;
            r_pendFlag <= 1'b0;
        end else begin
            if (w_frameEdge) begin
                r_pendFlag <= 1'b0;
            end
            if (w_strobeOk) begin
                r_pendCode <= patIf.i_pattern;
                r_pendFlag <= 1'b1;
            end
        end
    end

    // Swap in the pending pattern and advance the bar only at a frame edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_curPattern <= PAT_OFF;
            r_pos        <= '0;
        end else if (w_frameEdge) begin
            if (r_pendFlag) begin
                r_curPattern <= r_pendCode;
            end
            r_pos <= w_posNext;
        end
    end

    // One-cycle error pulse for an unsupported pattern code.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_errorFlag <= 1'b0;
        end else begin
            r_errorFlag <= w_strobeBad;
        end
    end

    // Stage 1: capture the pixel, syncs and the pattern state it will be drawn with.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_px1  <= '0;
            r_py1  <= '0;
            r_act1 <= 1'b0;
            r_hs1  <= SYNC_IDLE;
            r_vs1  <= SYNC_IDLE;
            r_pat1 <= PAT_OFF;
            r_pos1 <= '0;
        end else begin
            r_px1  <= i_px;
            r_py1  <= i_py;
            r_act1 <= i_activeArea;
            r_hs1  <= i_hs;
            r_vs1  <= i_vs;
            r_pat1 <= r_curPattern;
            r_pos1 <= r_pos;
        end
    end

    vga_pattern_colour u_colour (
        .i_pattern (r_pat1),
        .i_px      (r_px1),
        .i_py      (r_py1),
        .i_pos     (r_pos1),
        .o_rgb     (w_rgb)
    );

    // Stage 2: register colour (blanked outside the active area) and syncs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rgb2 <= '0;
            r_hs2  <= SYNC_IDLE;
            r_vs2  <= SYNC_IDLE;
        end else begin
            r_rgb2 <= r_act1 ? w_rgb : '0;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
        end
    end

    assign o_hs              = r_hs2;
    assign o_vs              = r_vs2;
    assign o_red             = r_rgb2.red;
    assign o_green           = r_rgb2.green;
    assign o_blue            = r_rgb2.blue;
    assign patIf.o_errorFlag = r_errorFlag;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: a behavioural model predicts each
// pixel's colour and syncs, pushes them on a queue, and the entry is popped
// and compared when the DUT emits that pixel two cycles later.
module tb_vga_pattern_gen;
    import vga_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       hs, vs, act;
    logic [9:0] px, py;
    logic       oHs, oVs;
    colour_t    oRed, oGreen, oBlue;

    vga_pattern_gen_if patIf ();

    vga_pattern_gen dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_hs         (hs),
        .i_vs         (vs),
        .i_activeArea (act),
        .i_px         (px),
        .i_py         (py),
        .patIf        (patIf),
        .o_hs         (oHs),
        .o_vs         (oVs),
        .o_red        (oRed),
        .o_green      (oGreen),
        .o_blue       (oBlue)
    );

    always #5 i_clk = ~i_clk;

    int          errCount   = 0;
    int          checkCount = 0;
    string       curTag     = "init";
    logic [10:0] expQ[$];

    int          mCur, mPend, mPos;
    bit          mFlag, mVsPrev;
    bit          saw636 = 0;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference colour computed arithmetically from the pattern definitions.
    function automatic logic [8:0] modelRgb(input int pat, input int x, input int y, input int pos, input bit a);
        int idx;
        logic [2:0] r, g, b;
        if (!a) return 9'h0;
        r = 0; g = 0; b = 0;
        case (pat)
            1: begin r = 7; g = 7; b = 7; end
            2: begin
                idx = (x / 64) % 8;
                r = ((idx / 4) % 2) ? 3'd7 : 3'd0;
                g = ((idx / 2) % 2) ? 3'd7 : 3'd0;
                b = (idx % 2)       ? 3'd7 : 3'd0;
            end
            3: if (((x / 32) % 2) != ((y / 32) % 2)) begin r = 7; g = 7; b = 7; end
            4: begin r = 3'((x / 64) % 8); g = 3'((y / 64) % 8); end
            5: if (x >= pos && x <= pos + 15) begin r = 7; g = 7; b = 7; end
            default: ;
        endcase
        return {r, g, b};
    endfunction

    task automatic modelReset();
        mCur = 0; mPend = 0; mFlag = 0; mPos = 0; mVsPrev = 1;
        expQ.delete();
    endtask

    // Drive one pixel cycle, predict its output, advance the model, then check.
    task automatic applyStimulus(input bit h, input bit v, input bit a, input int x, input int y,
                                 input bit pv, input int pat);
        bit errExp;
        logic [10:0] exp;
        hs = h; vs = v; act = a; px = 10'(x); py = 10'(y);
        patIf.i_patternValid = pv;
        patIf.i_pattern      = 3'(pat);
        expQ.push_back({modelRgb(mCur, x, y, mPos, a), h, v});
        errExp = pv && (pat >= 6);
        if (!v && mVsPrev) begin
            if (mFlag) begin mCur = mPend; mFlag = 0; end
            mPos = mPos + 4;
            if (mPos >= 640) mPos = 0;
        end
        if (pv && pat < 6) begin mPend = pat; mFlag = 1; end
        mVsPrev = v;
        @(posedge i_clk);
        #1;
        checkOutput({curTag, "/err"}, 32'(patIf.o_errorFlag), 32'(errExp));
        if (expQ.size() >= 2) begin
            exp = expQ.pop_front();
            checkOutput(curTag, {21'h0, oRed, oGreen, oBlue, oHs, oVs}, {21'h0, exp});
        end
    endtask

    task automatic pixel(input int x, input int y, input bit pv = 0, input int pat = 0);
        applyStimulus(1, 1, 1, x, y, pv, pat);
    endtask

    task automatic blankCycle(input bit pv = 0, input int pat = 0);
        applyStimulus(1, 1, 0, 700, 100, pv, pat);
    endtask

    // Vertical sync pulse; the optional strobe lands on the edge cycle itself.
    task automatic frameEdge(input bit pv = 0, input int pat = 0);
        applyStimulus(1, 0, 0, 0, 490, pv, pat);
        applyStimulus(1, 0, 0, 0, 491, 0, 0);
        applyStimulus(1, 1, 0, 0, 492, 0, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "/rgb"}, 32'({oRed, oGreen, oBlue}), 32'h0);
        checkOutput({tag, "/hs"},  32'(oHs), 32'h1);
        checkOutput({tag, "/vs"},  32'(oVs), 32'h1);
        checkOutput({tag, "/err"}, 32'(patIf.o_errorFlag), 32'h0);
    endtask

    initial begin
        i_reset = 1'b1;
        hs = 1; vs = 1; act = 0; px = 0; py = 0;
        patIf.i_patternValid = 0;
        patIf.i_pattern      = 0;
        modelReset();

        curTag = "resetHeld";
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            checkResetOutputs(curTag);
        end
        i_reset = 1'b0;

        curTag = "pattern0";
        blankCycle();
        applyStimulus(0, 1, 0, 660, 10, 0, 0);
        for (int x = 0; x < 640; x += 160) pixel(x, 10);
        frameEdge();
        pixel(64, 20); pixel(448, 20);

        curTag = "bars";
        pixel(100, 30, 1, 2);
        pixel(64, 30); pixel(448, 30);
        frameEdge();
        pixel(64, 40); pixel(448, 40);
        for (int x = 0; x < 512; x += 64) pixel(x + 5, 41);
        blankCycle(); blankCycle();

        curTag = "white";
        blankCycle(1, 1);
        frameEdge();
        pixel(0, 0); pixel(639, 479);
        blankCycle();
        pixel(320, 200);

        curTag = "checker";
        blankCycle(1, 3);
        frameEdge();
        pixel(32, 0); pixel(32, 32); pixel(0, 0); pixel(0, 32); pixel(95, 70);

        curTag = "lastWins";
        pixel(10, 10, 1, 3);
        pixel(11, 10, 1, 4);
        pixel(12, 10);
        frameEdge();
        pixel(128, 64); pixel(448, 300); pixel(600, 479);

        curTag = "badCode";
        pixel(128, 64, 1, 7);
        pixel(128, 64);
        blankCycle(1, 6);
        blankCycle();
        frameEdge();
        pixel(128, 64); pixel(256, 192);

        curTag = "edgeStrobe";
        frameEdge(1, 5);
        pixel(128, 64); pixel(4, 0);
        frameEdge();
        pixel(mPos, 0); pixel(mPos + 16, 0);

        curTag = "movingBar";
        for (int f = 0; f < 162; f++) begin
            frameEdge();
            if (mPos == 636) saw636 = 1;
            pixel(mPos, 5);
            pixel((mPos + 15 > 639) ? 639 : mPos + 15, 5);
            if (mPos + 16 < 640) pixel(mPos + 16, 5);
            if (mPos > 0) pixel(mPos - 1, 5);
            if (mPos == 636) begin
                pixel(637, 5); pixel(638, 5);
            end
            pixel(0, 5);
            pixel(639, 5);
        end
        checkOutput("movingBar/reached636", 32'(saw636), 32'h1);

        curTag = "midReset";
        frameEdge();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, mPos + i, 7, 0, 0);
        #3;
        i_reset = 1'b1;
        #1;
        checkResetOutputs("midResetAsync");
        @(posedge i_clk);
        #1;
        checkResetOutputs("midResetHeld");
        i_reset = 1'b0;
        modelReset();

        curTag = "afterReset";
        for (int x = 0; x < 16; x += 5) pixel(x, 8);
        pixel(20, 8, 1, 5);
        frameEdge();
        pixel(3, 9); pixel(4, 9); pixel(19, 9); pixel(20, 9);

        blankCycle(); blankCycle();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
